// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled Rx line, mid-bit start validation, 8 data bits
// LSB-first, optional odd/even parity, stop check, one-cycle valid strobe.
module uart_rx_core #(
    parameter int ClkFreqDiv0 = 650,
    parameter int ClkFreqDiv1 = 325,
    parameter int ClkFreqDiv2 = 162,
    parameter int ClkFreqDiv3 = 80,
    parameter int CountBits   = 10
) (
    input  logic       Clock,
    input  logic       ResetN,
    input  logic       Enable,
    input  logic       Rx,
    input  logic [1:0] BaudRate,
    input  logic [1:0] ParityType,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       ParityError,
    output logic       FrameError,
    output logic       Busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic [CountBits-1:0] div_for_baud(input logic [1:0] baud);
        case (baud)
            2'b00:   div_for_baud = CountBits'(ClkFreqDiv0);
            2'b01:   div_for_baud = CountBits'(ClkFreqDiv1);
            2'b10:   div_for_baud = CountBits'(ClkFreqDiv2);
            default: div_for_baud = CountBits'(ClkFreqDiv3);
        endcase
    endfunction

    function automatic logic parity_expected(input logic [7:0] data, input logic odd);
        parity_expected = (^data) ^ odd;
    endfunction

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q, rx_prev_q;
    logic [CountBits-1:0] tick_cnt_q, tick_cnt_d, final_q, final_s;
    logic                 tick_s, start_s, parity_on_s;
    logic [1:0]           ptype_q;
    logic [3:0]           samp_q, samp_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 busy_q, busy_d;

    // While idle the live BaudRate drives the divider; during a frame the latched one does.
    assign final_s     = (state_q == ST_IDLE) ? div_for_baud(BaudRate) : final_q;
    assign tick_s      = Enable & (tick_cnt_q >= final_s);
    assign start_s     = tick_s & (state_q == ST_IDLE) & ~rx_s_q & rx_prev_q;
    assign parity_on_s = (ptype_q == 2'b01) | (ptype_q == 2'b10);

    // Two-flop synchronizer; edge reference updates once per tick.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= Rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= tick_s ? rx_s_q : rx_prev_q;
        end
    end

    // Oversample tick divider next value.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (!Enable) begin
            tick_cnt_d = '0;
        end else if (tick_s) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + CountBits'(1);
        end
    end

    // State register.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every transition happens on a tick.
    always_comb begin
        state_d = state_q;
        if (!Enable) begin
            state_d = ST_IDLE;
        end else if (tick_s) begin
            case (state_q)
                ST_IDLE:   state_d = start_s ? ST_START : ST_IDLE;
                ST_START:  state_d = (samp_q == 4'd7) ? (rx_s_q ? ST_IDLE : ST_DATA) : ST_START;
                ST_DATA:   state_d = ((samp_q == 4'd15) && (idx_q == 3'd7))
                                     ? (parity_on_s ? ST_PARITY : ST_STOP) : ST_DATA;
                ST_PARITY: state_d = (samp_q == 4'd15) ? ST_STOP : ST_PARITY;
                ST_STOP:   state_d = (samp_q == 4'd15) ? ST_IDLE : ST_STOP;
                default:   state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Datapath and output next values per state.
    always_comb begin
        samp_d     = samp_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        busy_d     = (state_d != ST_IDLE);
        if (!Enable) begin
            samp_d = 4'd0;
            idx_d  = 3'd0;
        end else if (tick_s) begin
            case (state_q)
                ST_IDLE: begin
                    samp_d = 4'd0;
                    idx_d  = 3'd0;
                end
                ST_START: begin
                    samp_d = (samp_q == 4'd7) ? 4'd0 : samp_q + 4'd1;
                    idx_d  = 3'd0;
                end
                ST_DATA: begin
                    if (samp_q == 4'd15) begin
                        shift_d[idx_q] = rx_s_q;
                        samp_d         = 4'd0;
                        idx_d          = idx_q + 3'd1;
                    end else begin
                        samp_d = samp_q + 4'd1;
                    end
                end
                ST_PARITY: begin
                    if (samp_q == 4'd15) begin
                        par_bit_d = rx_s_q;
                        samp_d    = 4'd0;
                    end else begin
                        samp_d = samp_q + 4'd1;
                    end
                end
                ST_STOP: begin
                    if (samp_q == 4'd15) begin
                        rx_data_d  = shift_q;
                        frm_err_d  = ~rx_s_q;
                        par_err_d  = parity_on_s &
                                     (par_bit_q != parity_expected(shift_q, ptype_q == 2'b01));
                        rx_valid_d = 1'b1;
                        samp_d     = 4'd0;
                    end else begin
                        samp_d = samp_q + 4'd1;
                    end
                end
                default: begin
                    samp_d = 4'd0;
                    idx_d  = 3'd0;
                end
            endcase
        end else begin
            samp_d = samp_q;
        end
    end

    // Datapath, frame-latched settings and registered outputs.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            tick_cnt_q <= '0;
            final_q    <= '0;
            ptype_q    <= 2'b00;
            samp_q     <= 4'd0;
            idx_q      <= 3'd0;
            shift_q    <= 8'h00;
            par_bit_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            final_q    <= start_s ? div_for_baud(BaudRate) : final_q;
            ptype_q    <= start_s ? ParityType : ptype_q;
            samp_q     <= samp_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            busy_q     <= busy_d;
        end
    end

    assign RxData      = rx_data_q;
    assign RxValid     = rx_valid_q;
    assign ParityError = par_err_q;
    assign FrameError  = frm_err_q;
    assign Busy        = busy_q;

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receiver for the UART link: the receive-side counterpart of the transmit path and its baud generator. It oversamples the asynchronous `Rx` line at 16× the selected baud rate and validates the start bit at mid-bit. It then shifts in 8 data bits LSB-first, optionally checks parity, checks the stop bit, and presents the byte with a one-cycle valid strobe and error flags. It sits between the pad-side `Rx` pin and the receive FIFO or host logic.

## Interface
- `ClkFreqDiv0..3`: tick divider terminal counts `650`, `325`, `162`, `80`. At a 25 MHz `Clock` these give 16× oversampling for 2400, 4800, 9600 and 19200 baud.
- `CountBits`, default `10`: width of the oversample divider counter.
- `Clock`  in  1: system clock; all logic is on the rising edge.
- `ResetN`  in  1: asynchronous, active-low reset.
- `Enable`  in  1: receiver enable. Low forces the block idle.
- `Rx`  in  1: asynchronous serial input; idles high.
- `BaudRate`  in  2: `00`=2400, `01`=4800, `10`=9600, `11`=19200.
- `ParityType`  in  2: `01`=odd, `10`=even, `00` or `11`=no parity bit.
- `RxData`  out  8: last received byte. Held until the next frame completes.
- `RxValid`  out  1: one-`Clock` pulse when `RxData` and the error flags update.
- `ParityError`  out  1: the frame's parity bit mismatched. Updates with `RxValid`.
- `FrameError`  out  1: the stop bit was sampled low. Updates with `RxValid`.
- `Busy`  out  1: high from start-bit detection until return to IDLE.

## Operation
- **Synchronizer:** `Rx` passes through 2 flops before any use (`RxS`), plus one more flop (`RxPrev`) for edge detection. All three flops reset to 1.
- **Tick generator:**
  - Free-running counter, 0..FinalValue.
  - `Tick`=1 for one `Clock` when the count equals FinalValue; the counter then wraps to 0.
  - The counter runs only while `Enable`=1; otherwise it is held at 0.
- **Divider selection:** FinalValue is selected from `BaudRate` and latched on start detection, so a `BaudRate` change mid-frame has no effect until the next frame.
- **Oversample counter:** 4 bits, advances only on `Tick`.
- **State machine.** All transitions are evaluated on `Tick`; `RxS` is sampled on `Tick`.
  - IDLE:
    - On `Tick` with `RxS`=0 and `RxPrev`=1 (falling edge), clear the sample count and go to START.
    - A line that stays low, such as a break, does not retrigger.
  - START:
    - At sample count 7 (mid start bit), if `RxS`=0, clear the count and the bit index, then go to DATA.
    - Otherwise it is a false start: go to IDLE with no output change.
  - DATA:
    - At sample count 15, shift `RxS` into bit[index], LSB first, and clear the count.
    - After index 7, go to PARITY if `ParityType` is `01` or `10`; otherwise go to STOP.
  - PARITY:
    - At count 15, capture the parity bit.
    - Expected bit is XOR(data) for even parity and ~XOR(data) for odd parity.
    - Go to STOP.
  - STOP:
    - At count 15, load `RxData`.
    - Set `FrameError` = ~`RxS`.
    - Set `ParityError` to the mismatch result, forced to 0 when there is no parity bit.
    - Pulse `RxValid` and go to IDLE.
- **Other behaviour:**
  - `ParityType` is latched on start detection.
  - `Busy` is 1 in every state except IDLE.
  - `Enable`=0 in any state returns the block to IDLE immediately: counters clear, no `RxValid`, data outputs hold.
  - A frame with errors is still delivered: `RxValid`=1 with the flags set.

## Timing
- Reset values: `RxData`=0x00, `RxValid`=0, `ParityError`=0, `FrameError`=0, `Busy`=0; FSM in IDLE, all counters 0.
- One bit time = 16 × (FinalValue+1) `Clock` cycles; for example, 1296 cycles at `BaudRate`=`11`.
- Start-detect latency after an `Rx` falling edge: 2 synchronizer cycles plus up to 1 tick. `Busy` rises on the `Clock` after the detecting tick.
- Sampling points fall at mid-bit, ±1 tick.
- `RxValid` fires on the `Clock` following the stop-bit mid-sample tick. That is about 9.5 bit times after the start edge without parity, or 10.5 with parity.
- `Busy` falls in the same cycle that `RxValid` rises.
- Back-to-back frames: a start edge arriving half a bit after the stop sample is accepted.
- Asynchronous reset mid-frame clears all outputs on assertion. No partial byte is ever delivered.

## Test plan
- **Nominal byte:** `BaudRate`=`11`, no parity; send 0xA5 with 1 stop bit. Expect a single `RxValid` pulse with `RxData`=0xA5, `ParityError`=0, `FrameError`=0, about 9.5×1296 cycles after the start edge.
- **Even parity:** `ParityType`=`10`.
  - Send 0x3C with parity bit 0: `RxData`=0x3C, `ParityError`=0.
  - Resend with parity bit 1: `RxData`=0x3C, `ParityError`=1.
  - Repeat with odd parity: parity bit 1 passes.
- **Glitch rejection:** drive `Rx` low for 4 ticks, then high. Expect no `RxValid`; `Busy` pulses high and then returns to 0 by sample 7; `RxData` is unchanged.
- **Framing and break:** send 0x55 with the stop bit low. Expect `RxValid` with `RxData`=0x55 and `FrameError`=1. Holding `Rx` low afterwards produces no further frames; after `Rx` returns high, a subsequent 0x0F frame is received with `FrameError`=0.
- **Reset and enable mid-frame:**
  - Assert `ResetN`=0 during data bit 4: all outputs go to reset values at once, and the next full frame 0xC3 is received correctly.
  - Drop `Enable` mid-frame: `Busy` goes to 0 and no `RxValid` is produced.
- **Back-to-back and baud latch:** send 3 consecutive frames 0x00, 0xFF, 0x81 at `BaudRate`=`00`. Toggle `BaudRate` during frame 2. Expect all three bytes received in order with no errors.
